mem_traffic_gen: RTL and testbench

MEM_TRAFFIC_GEN -- requirements
Module: mem_traffic_gen

---
 rtl/mem_traffic_gen.sv | 190 +++++++++++++++++++
 tb/tb_mem_traffic_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_traffic_gen.sv
// mem_traffic_gen: line-oriented memory test generator (write pattern, read back, compare)
//
// Ports:
//    clk, rst_n          clock, synchronous active-low reset
//    start_i             one-cycle pulse starting a run (ignored while busy)
//    base_addr_i         first line address, sampled at start
//    num_lines_i         number of 32-byte lines, sampled at start
//    strobe_o            request valid; held with addr_o/rw_o/wdata_o until done_i
//    addr_o, rw_o        line address and direction (1 = write)
//    wdata_o             write line; 32-bit word k = (addr_o + 4k) ^ SEED
//    rdata_i, done_i     read line and one-cycle completion from the responder
//    busy_o              run in progress
//    pass_o, fail_o      run result, held until the next start
//    err_count_o         saturating count of mismatching read lines
//    first_err_addr_o    address of the first mismatching line
//    timeout_o           run aborted because done_i never arrived
//
// Build option: define TRAFFIC_GEN_TIMEOUT_EN to abort a request after
// TIMEOUT_CYCLES strobe-high cycles without done_i; otherwise the generator
// waits indefinitely and timeout_o stays 0.
module mem_traffic_gen #(
   parameter logic [31:0] SEED           = 32'hA5A5_0000,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic [31:0]   base_addr_i,
   input  logic [15:0]   num_lines_i,
   output logic          strobe_o,
   output logic [31:0]   addr_o,
   output logic          rw_o,
   output logic [255:0]  wdata_o,
   input  logic [255:0]  rdata_i,
   input  logic          done_i,
   output logic          busy_o,
   output logic          pass_o,
   output logic          fail_o,
   output logic [15:0]   err_count_o,
   output logic [31:0]   first_err_addr_o,
   output logic          timeout_o
);
   typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, FINISH} state_t;
   state_t         r_state, w_state_nx;
   logic           r_strobe, w_strobe_nx;
   logic [31:0]    r_addr, w_addr_nx;
   logic           r_rw, w_rw_nx;
   logic [15:0]    r_left, w_left_nx;
   logic [31:0]    r_base;
   logic [15:0]    r_num;
   logic           r_busy, w_busy_nx;
   logic           r_pass, w_pass_nx;
   logic           r_fail, w_fail_nx;
   logic           r_timeout, w_timeout_nx;
   logic [15:0]    r_err, w_err_nx;
   logic [31:0]    r_first, w_first_nx;
   logic [255:0]   w_exp;
   logic           w_mismatch;
   logic           w_last;
   logic           w_to_hit;
   function automatic logic [255:0] f_pattern(input logic [31:0] a);
      logic [255:0] p;
      p = '0;
      for (int k = 0; k < 8; k++) p[32*k +: 32] = (a + 32'(4 * k)) ^ SEED;
      return p;
   endfunction
   // The expected line is a pure function of the current address, so the
   // same value drives wdata_o during writes and is the compare reference
   // during reads; no line-wide register is needed.
   assign w_exp      = f_pattern(r_addr);
   assign w_mismatch = rdata_i != w_exp;
   assign w_last     = r_left == 16'd1;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
   logic [31:0] r_tcnt;
   assign w_to_hit = r_strobe && !done_i && (r_tcnt == 32'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (!rst_n) r_tcnt <= '0;
      else        r_tcnt <= (r_strobe && !done_i) ? r_tcnt + 32'd1 : '0;
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_to_hit         = 1'b0;
`endif
   always_comb begin
      w_state_nx   = r_state;
      w_strobe_nx  = r_strobe;
      w_addr_nx    = r_addr;
      w_rw_nx      = r_rw;
      w_left_nx    = r_left;
      w_busy_nx    = r_busy;
      w_pass_nx    = r_pass;
      w_fail_nx    = r_fail;
      w_timeout_nx = r_timeout;
      w_err_nx     = r_err;
      w_first_nx   = r_first;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_busy_nx    = 1'b1;
               w_pass_nx    = 1'b0;
               w_fail_nx    = 1'b0;
               w_timeout_nx = 1'b0;
               w_err_nx     = '0;
               w_first_nx   = '0;
               w_addr_nx    = base_addr_i;
               w_left_nx    = num_lines_i;
               w_rw_nx      = num_lines_i != '0;
               w_state_nx   = (num_lines_i == '0) ? FINISH : WR_REQ;
            end
         end
         WR_REQ, RD_REQ: begin
            // strobe low here is the mandatory gap cycle before each request
            if (!r_strobe) w_strobe_nx = 1'b1;
            else if (done_i) begin
               w_strobe_nx = 1'b0;
               if (r_state == RD_REQ && w_mismatch) begin
                  w_err_nx = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
                  if (r_err == '0) w_first_nx = r_addr;
               end
               if (!w_last) begin
                  w_addr_nx = r_addr + 32'd32;
                  w_left_nx = r_left - 16'd1;
               end else if (r_state == WR_REQ) begin
                  w_state_nx = RD_REQ;
                  w_rw_nx    = 1'b0;
                  w_addr_nx  = r_base;
                  w_left_nx  = r_num;
               end else w_state_nx = FINISH;
            end else if (w_to_hit) begin
               w_strobe_nx  = 1'b0;
               w_timeout_nx = 1'b1;
               w_fail_nx    = 1'b1;
               w_state_nx   = FINISH;
            end
         end
         FINISH: begin
            w_state_nx = IDLE;
            w_busy_nx  = 1'b0;
            w_rw_nx    = 1'b0;
            w_pass_nx  = (r_err == '0) && !r_timeout;
            w_fail_nx  = !((r_err == '0) && !r_timeout);
         end
         default: w_state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_strobe  <= 1'b0;
         r_addr    <= '0;
         r_rw      <= 1'b0;
         r_left    <= '0;
         r_base    <= '0;
         r_num     <= '0;
         r_busy    <= 1'b0;
         r_pass    <= 1'b0;
         r_fail    <= 1'b0;
         r_timeout <= 1'b0;
         r_err     <= '0;
         r_first   <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_strobe  <= w_strobe_nx;
         r_addr    <= w_addr_nx;
         r_rw      <= w_rw_nx;
         r_left    <= w_left_nx;
         r_busy    <= w_busy_nx;
         r_pass    <= w_pass_nx;
         r_fail    <= w_fail_nx;
         r_timeout <= w_timeout_nx;
         r_err     <= w_err_nx;
         r_first   <= w_first_nx;
         if (r_state == IDLE && start_i) begin
            r_base <= base_addr_i;
            r_num  <= num_lines_i;
         end
      end
   end
   assign strobe_o         = r_strobe;
   assign addr_o           = r_addr;
   assign rw_o             = r_rw;
   assign wdata_o          = r_rw ? w_exp : '0;
   assign busy_o           = r_busy;
   assign pass_o           = r_pass;
   assign fail_o           = r_fail;
   assign err_count_o      = r_err;
   assign first_err_addr_o = r_first;
   assign timeout_o        = r_timeout;
endmodule

// File: tb/tb_mem_traffic_gen.sv
// tb_mem_traffic_gen: directed and random runs of mem_traffic_gen against a memory responder and a line-sequence model
module tb_mem_traffic_gen;
   localparam logic [31:0] SEED = 32'hA5A5_0000;
   localparam int          TO   = 16;
   typedef struct packed {
      logic [31:0]  addr;
      logic         rw;
      logic [255:0] wdata;
      logic         stable;
   } txn_t;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic [31:0]  base_addr_i = '0;
   logic [15:0]  num_lines_i = '0;
   logic [255:0] rdata_i = '0;
   logic         done_i = 1'b0;
   logic         strobe_o, rw_o, busy_o, pass_o, fail_o, timeout_o;
   logic [31:0]  addr_o, first_err_addr_o;
   logic [255:0] wdata_o;
   logic [15:0]  err_count_o;
   int           n_chk = 0;
   int           n_fail = 0;
   int           rsp_delay = 3;
   bit           rsp_mute = 1'b0;
   bit           cor_en = 1'b0;
   logic [31:0]  cor_addr = '0;
   int           stray_req = 0;
   int           gap_bad = 0;
   txn_t         log[$];
   logic [255:0] mem [logic [31:0]];
   mem_traffic_gen #(.SEED(SEED), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
      .num_lines_i(num_lines_i), .strobe_o(strobe_o), .addr_o(addr_o), .rw_o(rw_o),
      .wdata_o(wdata_o), .rdata_i(rdata_i), .done_i(done_i), .busy_o(busy_o),
      .pass_o(pass_o), .fail_o(fail_o), .err_count_o(err_count_o),
      .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o)
   );
   always #5 clk = ~clk;
   function automatic logic [255:0] pattern(input logic [31:0] a);
      logic [255:0] p;
      for (int k = 0; k < 8; k++) p[32*k +: 32] = (a + 32'(4 * k)) ^ SEED;
      return p;
   endfunction
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Responder: answers each strobe after rsp_delay cycles, stores writes,
   // returns stored lines on reads (optionally with bit 0 flipped at cor_addr).
   initial begin : responder
      int cnt;
      int stray_done;
      bit stable;
      logic [31:0] ha;
      logic hrw;
      logic [255:0] hwd;
      cnt = 0;
      stray_done = 0;
      stable = 1'b1;
      forever begin
         @(negedge clk);
         if (done_i && strobe_o) gap_bad++;
         done_i = 1'b0;
         if (!strobe_o) cnt = 0;
         else begin
            cnt++;
            if (cnt == 1) begin
               ha = addr_o;
               hrw = rw_o;
               hwd = wdata_o;
               stable = 1'b1;
            end else if (addr_o !== ha || rw_o !== hrw || wdata_o !== hwd) stable = 1'b0;
            if (!rsp_mute && cnt >= rsp_delay) begin
               if (rw_o) mem[addr_o] = wdata_o;
               else rdata_i = (mem.exists(addr_o) ? mem[addr_o] : '0) ^ ((cor_en && addr_o == cor_addr) ? 256'd1 : 256'd0);
               log.push_back(txn_t'{addr_o, rw_o, wdata_o, stable});
               done_i = 1'b1;
               cnt = 0;
            end
         end
         if (stray_done != stray_req) begin
            stray_done = stray_req;
            done_i = 1'b1;
         end
      end
   end
   task automatic pulse_start(input logic [31:0] b, input int n);
      @(negedge clk);
      start_i = 1'b1;
      base_addr_i = b;
      num_lines_i = 16'(n);
      @(negedge clk);
      start_i = 1'b0;
      base_addr_i = $urandom;
      num_lines_i = 16'($urandom);
   endtask
   task automatic wait_idle(input string tag);
      int cyc;
      cyc = 0;
      while (busy_o && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      chk(tag, 256'(busy_o), 256'(0));
   endtask
   task automatic run(input logic [31:0] b, input int n, input bit ce, input logic [31:0] ca, input int d, input bit poke);
      int s, exp_err;
      logic [31:0] a, exp_first;
      bit w;
      exp_err = 0;
      exp_first = '0;
      rsp_delay = d;
      cor_en = ce;
      cor_addr = ca;
      s = log.size();
      pulse_start(b, n);
      chk("busy_after_start", 256'(busy_o), 256'(1));
      chk("no_strobe_at_start", 256'(strobe_o), 256'(0));
      chk("pass_cleared", 256'(pass_o), 256'(0));
      chk("fail_cleared", 256'(fail_o), 256'(0));
      chk("err_cleared", 256'(err_count_o), 256'(0));
      chk("first_cleared", 256'(first_err_addr_o), 256'(0));
      @(negedge clk);
      if (n == 0) begin
         chk("n0_pass", 256'(pass_o), 256'(1));
         chk("n0_busy", 256'(busy_o), 256'(0));
         chk("n0_strobe", 256'(strobe_o), 256'(0));
      end else begin
         chk("first_strobe", 256'(strobe_o), 256'(1));
         chk("first_addr", 256'(addr_o), 256'(b));
         chk("first_rw", 256'(rw_o), 256'(1));
         if (poke) begin
            start_i = 1'b1;
            base_addr_i = ~b;
            num_lines_i = 16'd7;
            @(negedge clk);
            start_i = 1'b0;
         end
      end
      wait_idle("run_done");
      chk("txn_count", 256'(log.size() - s), 256'(2 * n));
      for (int i = 0; i < 2 * n; i++) begin
         a = b + 32'((i % n) * 32);
         w = i < n;
         if (s + i < log.size()) begin
            chk("txn_addr", 256'(log[s+i].addr), 256'(a));
            chk("txn_rw", 256'(log[s+i].rw), 256'(w));
            chk("txn_stable", 256'(log[s+i].stable), 256'(1));
            if (w) chk("txn_wdata", log[s+i].wdata, pattern(a));
         end
         if (!w && ce && a == ca) begin
            exp_err++;
            if (exp_err == 1) exp_first = a;
         end
      end
      chk("err_count", 256'(err_count_o), 256'(exp_err));
      chk("first_err", 256'(first_err_addr_o), 256'(exp_first));
      chk("pass", 256'(pass_o), 256'(exp_err == 0));
      chk("fail", 256'(fail_o), 256'(exp_err != 0));
      chk("timeout_clear", 256'(timeout_o), 256'(0));
      chk("strobe_gap", 256'(gap_bad), 256'(0));
   endtask
   initial begin : stim
      int s, cyc, hi, n;
      logic [31:0] b;
      repeat (3) @(negedge clk);
      chk("rst_strobe", 256'(strobe_o), 256'(0));
      chk("rst_addr", 256'(addr_o), 256'(0));
      chk("rst_rw", 256'(rw_o), 256'(0));
      chk("rst_wdata", wdata_o, 256'(0));
      chk("rst_busy", 256'(busy_o), 256'(0));
      chk("rst_pass", 256'(pass_o), 256'(0));
      chk("rst_fail", 256'(fail_o), 256'(0));
      chk("rst_err", 256'(err_count_o), 256'(0));
      chk("rst_first", 256'(first_err_addr_o), 256'(0));
      chk("rst_timeout", 256'(timeout_o), 256'(0));
      rst_n = 1'b1;
      run(32'h8000_0000, 4, 1'b0, '0, 3, 1'b0);
      run(32'h8000_0000, 4, 1'b1, 32'h8000_0020, 3, 1'b0);
      run(32'h1234_5000, 0, 1'b0, '0, 3, 1'b0);
      run(32'hFFFF_FFE0, 2, 1'b0, '0, 3, 1'b0);
      run(32'h0000_4000, 3, 1'b1, 32'h0000_4040, 1, 1'b1);
      rsp_delay = 3;
      cor_en = 1'b0;
      s = log.size();
      pulse_start(32'h8000_0000, 4);
      cyc = 0;
      while (!(strobe_o && addr_o == 32'h8000_0020) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("second_write_seen", 256'(strobe_o && addr_o == 32'h8000_0020), 256'(1));
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_strobe", 256'(strobe_o), 256'(0));
      chk("mid_rst_addr", 256'(addr_o), 256'(0));
      chk("mid_rst_rw", 256'(rw_o), 256'(0));
      chk("mid_rst_wdata", wdata_o, 256'(0));
      chk("mid_rst_busy", 256'(busy_o), 256'(0));
      chk("mid_rst_pass", 256'(pass_o), 256'(0));
      chk("mid_rst_fail", 256'(fail_o), 256'(0));
      rst_n = 1'b1;
      stray_req++;
      repeat (5) @(negedge clk);
      chk("stray_done_strobe", 256'(strobe_o), 256'(0));
      chk("stray_done_busy", 256'(busy_o), 256'(0));
      chk("stray_done_pass", 256'(pass_o), 256'(0));
      chk("rst_txn_count", 256'(log.size() - s), 256'(1));
      run(32'h8000_0000, 4, 1'b0, '0, 3, 1'b0);
`ifdef TRAFFIC_GEN_TIMEOUT_EN
      rsp_mute = 1'b1;
      pulse_start(32'h0000_1000, 2);
      cyc = 0;
      while (!strobe_o && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      hi = 0;
      while (strobe_o && hi < 200) begin
         @(negedge clk);
         hi++;
      end
      chk("to_strobe_cycles", 256'(hi), 256'(TO));
      wait_idle("to_done");
      chk("to_timeout", 256'(timeout_o), 256'(1));
      chk("to_fail", 256'(fail_o), 256'(1));
      chk("to_pass", 256'(pass_o), 256'(0));
      rsp_mute = 1'b0;
`else
      rsp_mute = 1'b1;
      pulse_start(32'h0000_1000, 1);
      repeat (200) @(negedge clk);
      chk("wait_strobe_held", 256'(strobe_o), 256'(1));
      chk("wait_busy_held", 256'(busy_o), 256'(1));
      chk("wait_no_timeout", 256'(timeout_o), 256'(0));
      rsp_mute = 1'b0;
      wait_idle("wait_done");
      chk("wait_pass", 256'(pass_o), 256'(1));
      chk("wait_timeout", 256'(timeout_o), 256'(0));
`endif
      for (int r = 0; r < 6; r++) begin
         b = $urandom;
         n = int'($urandom_range(1, 5));
         run(b, n, 1'($urandom_range(0, 1)), b + 32'(32 * $urandom_range(0, n - 1)), int'($urandom_range(1, 4)), 1'b0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
